demux_sel_sequencer: RTL and testbench

Upstream sequencer for the 8-way 1-to-8 demultiplexer tree. It accepts an 8-bit frame over a valid/ready handshake and replays it serially, one channel per cycle. It drives the tree's 3-bit select and its single data input so that bit k of the frame appears on output line k. A per-frame channel mask suppresses unwanted channels, and a stall input pauses the sweep. With `dout_valid` low, `dout` is 0, so all eight tree outputs stay low.

---
 rtl/demux_sel_sequencer.sv | 97 +++++++++
 tb/tb_demux_sel_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_sel_sequencer.sv
// Serialises an accepted 8-bit frame onto a 1-to-8 demux tree, one channel per cycle,
// with per-frame channel masking and a stall that pauses the sweep.
module demux_sel_sequencer (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   input  logic [7:0] in_mask,
   input  logic       stall,
   output logic [2:0] sel,
   output logic       dout,
   output logic       dout_valid,
   output logic       busy,
   output logic       frame_done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   state_e     state_q, state_d;
   logic [2:0] ch_q, ch_d;
   logic [7:0] data_q, data_d;
   logic [7:0] mask_q, mask_d;
   logic       accept;

   // rst gates in_ready so nothing is accepted on the reset edge itself.
   assign in_ready = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && !rst;
   assign accept   = in_valid && in_ready;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ch_q    <= 3'd0;
         data_q  <= 8'd0;
         mask_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         data_q  <= data_d;
         mask_q  <= mask_d;
      end
   end

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      data_d  = data_q;
      mask_d  = mask_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (accept) begin
               state_d = ST_SHIFT;
               ch_d    = 3'd0;
               data_d  = in_data;
               mask_d  = in_mask;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (!stall) begin
               if (ch_q == 3'd7) begin
                  state_d = ST_DONE;
               end else begin
                  ch_d = ch_q + 3'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      sel        = 3'd0;
      dout       = 1'b0;
      dout_valid = 1'b0;
      busy       = 1'b0;
      frame_done = 1'b0;
      unique case (state_q)
         ST_SHIFT: begin
            sel        = ch_q;
            dout_valid = mask_q[ch_q] && !stall;
            dout       = mask_q[ch_q] && !stall && data_q[ch_q];
            busy       = 1'b1;
         end
         ST_DONE: frame_done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// Directed bench for demux_sel_sequencer: each task drives one scenario and checks
// cycle-by-cycle against hand-computed expectations.
module tb_demux_sel_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   logic [7:0] in_mask;
   logic       stall;
   logic       in_ready;
   logic [2:0] sel;
   logic       dout;
   logic       dout_valid;
   logic       busy;
   logic       frame_done;

   int checks   = 0;
   int failures = 0;

   demux_sel_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_mask    (in_mask),
      .stall      (stall),
      .sel        (sel),
      .dout       (dout),
      .dout_valid (dout_valid),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Offers a frame in the current cycle, checks in_ready, and returns at the start of cycle N+1.
   task automatic offer(input logic [7:0] d, input logic [7:0] m, input logic hold);
      in_valid = 1'b1;
      in_data  = d;
      in_mask  = m;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL offer_ready: got in_ready=%b want 1", in_ready);
      end
      next_cycle();
      if (!hold) begin
         in_valid = 1'b0;
         in_data  = 8'h00;
         in_mask  = 8'h00;
      end
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'hFF;
      in_mask  = 8'hFF;
      stall    = 1'b0;
      next_cycle();
      next_cycle();
      @(negedge clk);
      checks++;
      if ({in_ready, sel, dout, dout_valid, busy, frame_done} !== 8'b0) begin
         failures++;
         $display("FAIL reset_outputs: got ready=%b sel=%0d dout=%b dv=%b busy=%b fd=%b want all 0",
                  in_ready, sel, dout, dout_valid, busy, frame_done);
      end
      next_cycle();
      rst      = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_release: got ready=%b busy=%b want ready=1 busy=0", in_ready, busy);
      end
      next_cycle();
   endtask

   task automatic test_basic();
      logic [7:0] exp_dout = 8'b1010_0101;
      offer(8'hA5, 8'hFF, 1'b0);
      in_data = 8'h00;
      in_mask = 8'h00;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         checks++;
         if (sel !== k[2:0] || dout !== exp_dout[k] || dout_valid !== 1'b1 || busy !== 1'b1 ||
             frame_done !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_ch%0d: got sel=%0d dout=%b dv=%b busy=%b fd=%b rdy=%b want sel=%0d dout=%b dv=1 busy=1 fd=0 rdy=0",
                     k, sel, dout, dout_valid, busy, frame_done, in_ready, k, exp_dout[k]);
         end
         next_cycle();
      end
      @(negedge clk);
      checks++;
      if (frame_done !== 1'b1 || busy !== 1'b0 || dout_valid !== 1'b0 || sel !== 3'd0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL basic_done: got fd=%b busy=%b dv=%b sel=%0d rdy=%b want fd=1 busy=0 dv=0 sel=0 rdy=1",
                  frame_done, busy, dout_valid, sel, in_ready);
      end
      next_cycle();
      @(negedge clk);
      checks++;
      if (frame_done !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL basic_idle: got fd=%b busy=%b want 0 0", frame_done, busy);
      end
      next_cycle();
   endtask

   task automatic test_mask();
      logic [7:0] exp_on = 8'b0000_1111;
      offer(8'hFF, 8'h0F, 1'b0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         checks++;
         if (sel !== k[2:0] || dout !== exp_on[k] || dout_valid !== exp_on[k] || busy !== 1'b1) begin
            failures++;
            $display("FAIL mask_ch%0d: got sel=%0d dout=%b dv=%b busy=%b want sel=%0d dout=%b dv=%b busy=1",
                     k, sel, dout, dout_valid, busy, k, exp_on[k], exp_on[k]);
         end
         next_cycle();
      end
      @(negedge clk);
      checks++;
      if (frame_done !== 1'b1) begin
         failures++;
         $display("FAIL mask_done: got fd=%b want 1", frame_done);
      end
      next_cycle();
      next_cycle();
   endtask

   task automatic test_back_to_back();
      logic [2:0] exp_sel;
      logic       exp_dout, exp_dv, exp_fd, exp_rdy;
      offer(8'h01, 8'hFF, 1'b1);
      in_data = 8'h80;
      for (int c = 1; c <= 18; c++) begin
         if (c == 10) in_valid = 1'b0;
         exp_sel  = 3'd0;
         exp_dout = 1'b0;
         exp_dv   = 1'b0;
         exp_fd   = 1'b0;
         exp_rdy  = 1'b0;
         if (c <= 8) begin
            exp_sel  = 3'(c - 1);
            exp_dv   = 1'b1;
            exp_dout = (c == 1);
         end else if (c == 9 || c == 18) begin
            exp_fd  = 1'b1;
            exp_rdy = 1'b1;
         end else begin
            exp_sel  = 3'(c - 10);
            exp_dv   = 1'b1;
            exp_dout = (c == 17);
         end
         @(negedge clk);
         checks++;
         if (sel !== exp_sel || dout !== exp_dout || dout_valid !== exp_dv ||
             frame_done !== exp_fd || in_ready !== exp_rdy) begin
            failures++;
            $display("FAIL b2b_cyc%0d: got sel=%0d dout=%b dv=%b fd=%b rdy=%b want sel=%0d dout=%b dv=%b fd=%b rdy=%b",
                     c, sel, dout, dout_valid, frame_done, in_ready, exp_sel, exp_dout, exp_dv, exp_fd, exp_rdy);
         end
         next_cycle();
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || frame_done !== 1'b0) begin
         failures++;
         $display("FAIL b2b_idle: got busy=%b fd=%b want 0 0", busy, frame_done);
      end
      next_cycle();
   endtask

   task automatic test_stall();
      logic [2:0] exp_sel;
      logic       exp_dv, exp_fd;
      offer(8'hFF, 8'hFF, 1'b0);
      for (int c = 1; c <= 11; c++) begin
         stall   = (c == 4 || c == 5);
         exp_fd  = (c == 11);
         exp_dv  = !(c == 4 || c == 5 || c == 11);
         exp_sel = (c <= 3) ? 3'(c - 1) : (c <= 5) ? 3'd3 : (c <= 10) ? 3'(c - 3) : 3'd0;
         @(negedge clk);
         checks++;
         if (sel !== exp_sel || dout_valid !== exp_dv || dout !== exp_dv || frame_done !== exp_fd ||
             busy !== !exp_fd) begin
            failures++;
            $display("FAIL stall_cyc%0d: got sel=%0d dv=%b dout=%b fd=%b busy=%b want sel=%0d dv=%b dout=%b fd=%b busy=%b",
                     c, sel, dout_valid, dout, frame_done, busy, exp_sel, exp_dv, exp_dv, exp_fd, !exp_fd);
         end
         next_cycle();
      end
      stall = 1'b0;
      next_cycle();
   endtask

   task automatic test_reset_mid();
      logic saw_done = 1'b0;
      logic saw_busy = 1'b0;
      offer(8'hFF, 8'hFF, 1'b0);
      for (int c = 1; c <= 5; c++) next_cycle();
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (sel !== 3'd5 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_pre: got sel=%0d rdy=%b want sel=5 rdy=0", sel, in_ready);
      end
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({sel, dout, dout_valid, busy, frame_done} !== 7'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL rstmid_post: got sel=%0d dout=%b dv=%b busy=%b fd=%b rdy=%b want all 0 rdy=1",
                  sel, dout, dout_valid, busy, frame_done, in_ready);
      end
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         saw_done |= frame_done;
         saw_busy |= busy;
         next_cycle();
      end
      checks++;
      if (saw_done !== 1'b0 || saw_busy !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_quiet: got saw_fd=%b saw_busy=%b want 0 0", saw_done, saw_busy);
      end
   endtask

   task automatic test_zero_mask();
      int busy_cnt = 0;
      logic saw_dv = 1'b0;
      offer(8'hFF, 8'h00, 1'b0);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (busy === 1'b1) busy_cnt++;
         saw_dv |= dout_valid | dout;
         next_cycle();
      end
      checks++;
      if (busy_cnt != 8 || saw_dv !== 1'b0) begin
         failures++;
         $display("FAIL zmask_shift: got busy_cycles=%0d saw_dv=%b want 8 0", busy_cnt, saw_dv);
      end
      @(negedge clk);
      checks++;
      if (frame_done !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL zmask_done: got fd=%b busy=%b want 1 0", frame_done, busy);
      end
      next_cycle();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_mask();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      test_zero_mask();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
